// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-channel arbitrating mux.
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Cyclic successor of idx in the range [0, n).
  function automatic int unsigned cyc_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first request found after ptr, with wrap.
module rr_arbiter_n
  import arb_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx
);

  int unsigned     idx;
  logic [SELW-1:0] idx_s;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = int'(ptr);
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx   = cyc_inc(idx, N);
      idx_s = SELW'(idx);
      if (!found && req[idx_s]) begin
        found      = 1'b1;
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating mux with a one-entry registered output and valid/ready on all sides.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic [N-1:0]     rr_gnt, fx_gnt, grant;
  logic [SELW-1:0]  rr_idx, gnt_idx;
  logic [WIDTH-1:0] sel_data;
  logic             can_load, xfer;

  rr_arbiter_n #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Out-of-range sel (non-power-of-2 N) grants nothing.
  always_comb begin
    fx_gnt = '0;
    if (int'(sel) < N) fx_gnt[sel] = in_valid[sel];
  end

  assign grant   = (mode == MODE_RR) ? rr_gnt : fx_gnt;
  assign gnt_idx = (mode == MODE_RR) ? rr_idx : sel;

  // Ready is withheld while reset is asserted so no producer sees a handshake.
  assign can_load = rst_n && (!out_valid || out_ready);
  assign in_ready = grant & {N{can_load}};
  assign xfer     = |(in_valid & in_ready);

  // grant is one-hot, so an AND-OR mux avoids any out-of-range part-select.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) sel_data |= in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= gnt_idx;
      if (mode == MODE_RR) rr_ptr <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
